seq_multiplier: RTL and testbench

Iterative, parametrised signed/unsigned integer multiplier for the execute stage's HI/LO unit.
- Retires `StepBits` multiplier bits per clock, trading latency for area instead of one large combinational adder tree.
- Supports plain multiply and, when configured, multiply-accumulate/subtract into a caller-supplied 2×`BitWidth` accumulator.
- Uses a start/ready/valid handshake so the pipeline can stall on `busy` and kill an operation with `cancel`.

---
 rtl/mult_pkg.sv | 39 +++
 rtl/mult_step.sv | 49 ++++
 rtl/seq_multiplier.sv | 200 ++++++++++++++++++++
 tb/tb_seq_multiplier.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the iterative multiplier: operation codes, FSM states,
// default-width word typedefs and the raw-opcode decoder.
// Optional feature macro: SEQ_MULT_ACCUMULATE_EN (enables MADD/MSUB).
package mult_pkg;

    // Operand width the HI/LO unit is normally built with.
    localparam int unsigned MULT_DEF_WIDTH = 32;

    // Word and double-word helpers for the default operand width.
    typedef logic [MULT_DEF_WIDTH-1:0]   mult_word_t;
    typedef logic [2*MULT_DEF_WIDTH-1:0] mult_dword_t;

    // Final-stage operation applied to the unsigned/signed product.
    typedef enum logic [1:0] {
        MUL  = 2'd0,
        MADD = 2'd1,
        MSUB = 2'd2
    } mult_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_e;

    // Opcode 3 is reserved and behaves as a plain multiply.
    function automatic mult_op_e decode_op(input logic [1:0] raw);
        mult_op_e res;
        case (raw)
            2'd1:    res = MADD;
            2'd2:    res = MSUB;
            default: res = MUL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One iteration of the radix-2^StepBits right-shifting multiplier:
// adds mcand * digit into the upper half of the running product and
// shifts the whole product right by StepBits.
module mult_step #(
    parameter int BitWidth = 32,
    parameter int StepBits = 2
) (
    input  logic [2*BitWidth-1:0] acc_i,
    input  logic [BitWidth-1:0]   mcand_i,
    input  logic [StepBits-1:0]   digit_i,
    output logic [2*BitWidth-1:0] acc_o
);

    localparam int SumW = BitWidth + StepBits;

    logic [SumW-1:0] pp_term [StepBits];
    logic [SumW-1:0] pp_sum;
    logic [SumW-1:0] sum;
    logic            unused_low;

    // One shifted copy of the multiplicand per digit bit.
    generate
        for (genvar gi = 0; gi < StepBits; gi++) begin : g_pp
            assign pp_term[gi] = digit_i[gi] ? (SumW'(mcand_i) << gi) : '0;
        end
    endgenerate

    // Sum the partial products and add them to the upper half; the sum
    // cannot overflow SumW bits because the upper half is below 2^BitWidth.
    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < StepBits; i++) begin
            pp_sum = pp_sum + pp_term[i];
        end
        sum = SumW'(acc_i[2*BitWidth-1:BitWidth]) + pp_sum;
    end

    // The StepBits lowest bits fall off the end on every shift.
    generate
        if (StepBits < BitWidth) begin : g_shift
            assign acc_o = {sum, acc_i[BitWidth-1:StepBits]};
        end else begin : g_whole
            assign acc_o = sum;
        end
    endgenerate

    assign unused_low = ^acc_i[StepBits-1:0];

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier for the HI/LO unit. Retires
// StepBits multiplier bits per clock on operand magnitudes, then applies
// the sign and the optional accumulate in a single FIX cycle.
// Optional feature macro: SEQ_MULT_ACCUMULATE_EN (MADD/MSUB with accIn).
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int BitWidth = 32,
    parameter int StepBits = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cancel,
    input  logic                  isUnsigned,
    input  logic [1:0]            op,
    input  logic [BitWidth-1:0]   multiplicand,
    input  logic [BitWidth-1:0]   multiplier,
    input  logic [2*BitWidth-1:0] accIn,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic [2*BitWidth-1:0] product
);

    localparam int N    = BitWidth / StepBits;
    localparam int DW   = 2 * BitWidth;
    localparam int CntW = (N > 1) ? $clog2(N) : 1;

    // StepBits must split the operand into whole digits.
    generate
        if ((BitWidth % StepBits) != 0) begin : g_bad_step
            $error("seq_multiplier: StepBits must divide BitWidth");
        end
    endgenerate

    mult_state_e         state_q,   state_d;
    logic [BitWidth-1:0] mcand_q,   mcand_d;
    logic [BitWidth-1:0] mplier_q,  mplier_d;
    logic [DW-1:0]       acc_q,     acc_d;
    logic [CntW-1:0]     cnt_q,     cnt_d;
    logic                neg_q,     neg_d;
    logic [DW-1:0]       product_q, product_d;
    logic                valid_q,   valid_d;
`ifdef SEQ_MULT_ACCUMULATE_EN
    mult_op_e            op_q,      op_d;
    logic [DW-1:0]       acc_in_q,  acc_in_d;
`else
    logic                unused_acc_inputs;
`endif

    logic [BitWidth-1:0] mag_a;
    logic [BitWidth-1:0] mag_b;
    logic                neg_in;
    logic [DW-1:0]       step_acc;
    logic [DW-1:0]       signed_p;
    logic [DW-1:0]       final_p;
    logic                load;

    // Operand magnitudes and result sign, computed at accept time.
    always_comb begin
        mag_a  = (!isUnsigned && multiplicand[BitWidth-1]) ?
                 ~(multiplicand - BitWidth'(1)) : multiplicand;
        mag_b  = (!isUnsigned && multiplier[BitWidth-1]) ?
                 ~(multiplier - BitWidth'(1)) : multiplier;
        neg_in = !isUnsigned && (multiplicand[BitWidth-1] ^ multiplier[BitWidth-1]);
    end

    mult_step #(
        .BitWidth (BitWidth),
        .StepBits (StepBits)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .digit_i (mplier_q[StepBits-1:0]),
        .acc_o   (step_acc)
    );

    // Re-apply the sign, then the optional accumulate; all wraps mod 2^DW.
    always_comb begin
        signed_p = neg_q ? -acc_q : acc_q;
`ifdef SEQ_MULT_ACCUMULATE_EN
        case (op_q)
            MADD:    final_p = acc_in_q + signed_p;
            MSUB:    final_p = acc_in_q - signed_p;
            default: final_p = signed_p;
        endcase
`else
        final_p = signed_p;
`endif
    end

`ifndef SEQ_MULT_ACCUMULATE_EN
    assign unused_acc_inputs = ^{op, accIn};
`endif

    // Next-state and datapath control; cancel only acts in CALC/FIX so a
    // start in DONE always wins over a simultaneous cancel.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        valid_d   = 1'b0;
        load      = 1'b0;
`ifdef SEQ_MULT_ACCUMULATE_EN
        op_d      = op_q;
        acc_in_d  = acc_in_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = step_acc;
                    mplier_d = mplier_q >> StepBits;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(N - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    product_d = final_p;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d  = CALC;
            mcand_d  = mag_a;
            mplier_d = mag_b;
            neg_d    = neg_in;
            acc_d    = '0;
            cnt_d    = '0;
`ifdef SEQ_MULT_ACCUMULATE_EN
            op_d     = decode_op(op);
            acc_in_d = accIn;
`endif
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            valid_q   <= 1'b0;
`ifdef SEQ_MULT_ACCUMULATE_EN
            op_q      <= MUL;
            acc_in_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            valid_q   <= valid_d;
`ifdef SEQ_MULT_ACCUMULATE_EN
            op_q      <= op_d;
            acc_in_q  <= acc_in_d;
`endif
        end
    end

    assign ready   = (state_q == IDLE) || (state_q == DONE);
    assign busy    = !ready;
    assign valid   = valid_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier; instance 0 uses StepBits=2, instances
// 1 and 2 use StepBits=1 and 4 for the back-to-back runs.
// Optional feature macro: SEQ_MULT_ACCUMULATE_EN (changes MADD/MSUB results).
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n;

    logic        start_v  [3];
    logic        cancel_v [3];
    logic        uns_v    [3];
    logic [1:0]  op_v     [3];
    logic [31:0] a_v      [3];
    logic [31:0] b_v      [3];
    logic [63:0] acc_v    [3];
    logic        ready_v  [3];
    logic        busy_v   [3];
    logic        valid_v  [3];
    logic [63:0] prod_v   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int SB = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
            seq_multiplier #(
                .BitWidth (32),
                .StepBits (SB)
            ) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .start        (start_v[gi]),
                .cancel       (cancel_v[gi]),
                .isUnsigned   (uns_v[gi]),
                .op           (op_v[gi]),
                .multiplicand (a_v[gi]),
                .multiplier   (b_v[gi]),
                .accIn        (acc_v[gi]),
                .ready        (ready_v[gi]),
                .busy         (busy_v[gi]),
                .valid        (valid_v[gi]),
                .product      (prod_v[gi])
            );
        end
    endgenerate

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int step_of(input int idx);
        return (idx == 0) ? 2 : ((idx == 1) ? 1 : 4);
    endfunction

    // Reference result built from the simulator's own 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic uns, input logic [1:0] opv,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] acc);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        if (uns) begin
            p = {32'd0, a} * {32'd0, b};
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
        end
`ifdef SEQ_MULT_ACCUMULATE_EN
        if (opv == 2'd1) p = acc + p;
        else if (opv == 2'd2) p = acc - p;
`endif
        return p;
    endfunction

    task automatic drive(input int idx, input logic uns, input logic [1:0] opv,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc);
        uns_v[idx] = uns;
        op_v[idx]  = opv;
        a_v[idx]   = a;
        b_v[idx]   = b;
        acc_v[idx] = acc;
    endtask

    // Counts clocks (accept clock = 1) until valid, bounded at 200.
    task automatic wait_valid(input int idx, output int lat);
        lat = 1;
        while (!valid_v[idx] && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input int idx, input logic uns, input logic [1:0] opv,
                          input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc,
                          output int lat);
        drive(idx, uns, opv, a, b, acc);
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
        wait_valid(idx, lat);
    endtask

    // Back-to-back random operations; each new start is raised in DONE.
    task automatic b2b(input int idx, input int nops);
        int          lat;
        logic        u;
        logic [1:0]  opv;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        for (int i = 0; i < nops; i++) begin
            u   = 1'($urandom_range(0, 1));
            opv = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            acc = {$urandom, $urandom};
            if (i == 0) a = 32'h8000_0000;
            drive(idx, u, opv, a, b, acc);
            start_v[idx]  = 1'b1;
            cancel_v[idx] = (i % 3 == 2);
            tick();
            start_v[idx]  = 1'b0;
            cancel_v[idx] = 1'b0;
            wait_valid(idx, lat);
            check_val($sformatf("b2b_s%0d_op%0d_lat", step_of(idx), i), 64'(lat),
                      64'(32 / step_of(idx) + 2));
            check_val($sformatf("b2b_s%0d_op%0d_prod", step_of(idx), i), prod_v[idx],
                      ref_mul(u, opv, a, b, acc));
        end
        tick();
    endtask

    initial begin
        int lat;
        int nvalid;
        logic [63:0] exp_madd;
        logic [63:0] exp_msub;

        for (int i = 0; i < 3; i++) begin
            start_v[i]  = 1'b0;
            cancel_v[i] = 1'b0;
            drive(i, 1'b0, 2'd0, 32'd0, 32'd0, 64'd0);
        end
        rst_n = 1'b0;
        repeat (3) tick();
        check_val("rst_product", prod_v[0], 64'd0);
        check_val("rst_valid", 64'(valid_v[0]), 64'd0);
        check_val("rst_ready", 64'(ready_v[0]), 64'd1);
        check_val("rst_busy", 64'(busy_v[0]), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(0, 1'b0, 2'd0, 32'hFFFF_FFFD, 32'd7, 64'd0, lat);
        check_val("neg3x7_lat", 64'(lat), 64'd18);
        check_val("neg3x7_prod", prod_v[0], 64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        check_val("neg3x7_valid_1cyc", 64'(valid_v[0]), 64'd0);

        run_op(0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, lat);
        check_val("umax_lat", 64'(lat), 64'd18);
        check_val("umax_prod", prod_v[0], 64'hFFFF_FFFE_0000_0001);

        run_op(0, 1'b0, 2'd0, 32'h8000_0000, 32'h8000_0000, 64'd0, lat);
        check_val("smin_lat", 64'(lat), 64'd18);
        check_val("smin_prod", prod_v[0], 64'h4000_0000_0000_0000);

`ifdef SEQ_MULT_ACCUMULATE_EN
        exp_madd = 64'h0000_0001_0000_0006;
        exp_msub = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp_madd = 64'h0000_0000_0000_0006;
        exp_msub = 64'h0000_0000_0000_0001;
`endif
        run_op(0, 1'b0, 2'd1, 32'd2, 32'd3, 64'h0000_0001_0000_0000, lat);
        check_val("madd_lat", 64'(lat), 64'd18);
        check_val("madd_prod", prod_v[0], exp_madd);

        run_op(0, 1'b0, 2'd2, 32'd1, 32'd1, 64'd0, lat);
        check_val("msub_lat", 64'(lat), 64'd18);
        check_val("msub_prod", prod_v[0], exp_msub);
        tick();

        // start pulses while busy must not disturb the running 5 x 6
        drive(0, 1'b1, 2'd0, 32'd5, 32'd6, 64'd0);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        lat = 1;
        while (!valid_v[0] && lat < 200) begin
            if (lat == 3 || lat == 10) begin
                check_val($sformatf("ign_busy_c%0d", lat), 64'(busy_v[0]), 64'd1);
                drive(0, 1'b1, 2'd0, 32'd100, 32'd100, 64'd0);
                start_v[0] = 1'b1;
            end else begin
                start_v[0] = 1'b0;
            end
            tick();
            lat++;
        end
        start_v[0] = 1'b0;
        check_val("ign_lat", 64'(lat), 64'd18);
        check_val("ign_prod", prod_v[0], 64'd30);
        tick();

        // cancel at cycle 5 of a 7 x 9
        drive(0, 1'b1, 2'd0, 32'd7, 32'd9, 64'd0);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (4) tick();
        cancel_v[0] = 1'b1;
        tick();
        cancel_v[0] = 1'b0;
        check_val("cancel_ready", 64'(ready_v[0]), 64'd1);
        check_val("cancel_busy", 64'(busy_v[0]), 64'd0);
        nvalid = 0;
        repeat (25) begin
            tick();
            if (valid_v[0]) nvalid++;
        end
        check_val("cancel_no_valid", 64'(nvalid), 64'd0);
        check_val("cancel_prod_kept", prod_v[0], 64'd30);

        // asynchronous reset in CALC cycle 8
        drive(0, 1'b1, 2'd0, 32'd11, 32'd13, 64'd0);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check_val("arst_product", prod_v[0], 64'd0);
        check_val("arst_valid", 64'(valid_v[0]), 64'd0);
        check_val("arst_ready", 64'(ready_v[0]), 64'd1);
        check_val("arst_busy", 64'(busy_v[0]), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(0, 1'b0, 2'd0, 32'd12345, 32'hFFFF_FFFE, 64'd0, lat);
        check_val("post_rst_lat", 64'(lat), 64'd18);
        check_val("post_rst_prod", prod_v[0], 64'hFFFF_FFFF_FFFF_9F8E);
        tick();

        b2b(0, 6);
        b2b(1, 6);
        b2b(2, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so a stuck design cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
